// File: rtl/hvl_pkg.sv
// Shared widths for the host <-> DUT pin bridge: 12-bit words split 8 low / 4 high pins.
package hvl_pkg;
  localparam int WORD_W    = 12;
  localparam int PIN_LO_W  = 8;
  localparam int PIN_HI_W  = 4;
  localparam int DEPTH_DEF = 4;
endpackage

// File: rtl/hvl_word_fifo.sv
// Word FIFO, DEPTH entries; head is combinational from the read pointer (push-to-head latency 1).
// No internal protection: the caller only pushes when !full (or popping) and only pops when !empty.
module hvl_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic [W-1:0]  head
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

  // When full, wr_ptr == rd_ptr; a same-cycle pop reads the old head before the write lands.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end
endmodule

// File: rtl/hvl_io_bridge.sv
// Host valid/ready streams <-> DUT pin words via two FIFOs; 1-cycle latency each way.
// s_ready drops when the input FIFO is full; strobes into a full output FIFO are dropped and flagged.
module hvl_io_bridge
  import hvl_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WORD_W = hvl_pkg::WORD_W,
  localparam int LW    = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] pin_in,
  input  logic              pin_in_take,
  input  logic [WORD_W-1:0] pin_out,
  input  logic              pin_out_strobe,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [LW-1:0]     in_level,
  output logic [LW-1:0]     out_level,
  output logic              err_underrun,
  output logic              err_overflow,
  input  logic              err_clear
);
  logic              in_full, in_empty, in_push, in_pop;
  logic              out_full, out_empty, out_push, out_pop;
  logic [WORD_W-1:0] in_head, out_head, out_word;
  logic              underrun_evt, overflow_evt;
  logic [PIN_LO_W-1:0] in_lo, out_lo;
  logic [PIN_HI_W-1:0] in_hi, out_hi;

  assign s_ready = !in_full;
  assign in_push = s_valid && s_ready;
  assign in_pop  = pin_in_take && !in_empty;
  assign underrun_evt = pin_in_take && in_empty;

  assign m_valid  = !out_empty;
  assign out_pop  = m_valid && m_ready;
  // A full output FIFO still accepts a strobe when the host drains a word the same cycle.
  assign out_push = pin_out_strobe && (!out_full || out_pop);
  assign overflow_evt = pin_out_strobe && out_full && !out_pop;

  // Pin mapping: low byte to ui_in / uo_out, high nibble to uio_in[3:0] / uio_out[7:4].
  assign in_lo    = in_head[PIN_LO_W-1:0];
  assign in_hi    = in_head[PIN_LO_W +: PIN_HI_W];
  assign pin_in   = in_empty ? '0 : {in_hi, in_lo};
  assign out_lo   = pin_out[PIN_LO_W-1:0];
  assign out_hi   = pin_out[PIN_LO_W +: PIN_HI_W];
  assign out_word = {out_hi, out_lo};
  assign m_data   = out_empty ? '0 : out_head;

  hvl_word_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_in_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(in_push), .push_data(s_data), .pop(in_pop),
    .full(in_full), .empty(in_empty), .level(in_level), .head(in_head)
  );

  hvl_word_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_out_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(out_push), .push_data(out_word), .pop(out_pop),
    .full(out_full), .empty(out_empty), .level(out_level), .head(out_head)
  );

  // Sticky flags; a same-cycle event beats err_clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
    end else if (err_clear) begin
      err_underrun <= underrun_evt;
      err_overflow <= overflow_evt;
    end else begin
      err_underrun <= err_underrun | underrun_evt;
      err_overflow <= err_overflow | overflow_evt;
    end
  end
endmodule

// File: doc/hvl_io_bridge.md
HVL_IO_BRIDGE -- requirements
Module: hvl_io_bridge

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the entry count of each of the two word FIFOs (power of two, 2..16).
REQ-002 Parameter WORD_W, default 12, SHALL set the stream word width, matching the 12-bit DUT data path (8 bits low, 4 bits high).
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 s_data  in  12  host word to send to the DUT.
REQ-006 s_valid / s_ready  in / out  1 / 1  host-to-bridge handshake.
REQ-007 pin_in  out  12  word driven onto DUT inputs ([7:0] to ui_in, [11:8] to uio_in[3:0]).
REQ-008 pin_in_take  in  1  DUT-side pulse: current pin_in word consumed.
REQ-009 pin_out  in  12  DUT output word ({uio_out[7:4], uo_out[7:0]}).
REQ-010 pin_out_strobe  in  1  DUT-side pulse: pin_out holds a new word.
REQ-011 m_data / m_valid / m_ready  out / out / in  12 / 1 / 1  bridge-to-host handshake.
REQ-012 in_level / out_level  out  clog2(DEPTH)+1  current occupancy of each FIFO.
REQ-013 err_underrun / err_overflow  out  1 / 1  sticky error flags.
REQ-014 err_clear  in  1  synchronous clear of both sticky flags.

Function
REQ-015 A transfer on either host port SHALL occur on a cycle where valid and ready are both 1.
REQ-016 s_ready SHALL be 1 exactly when in_level < DEPTH, derived from registered state only.
REQ-017 pin_in SHALL be the input-FIFO head word when in_level > 0, and 12'h000 when empty.
REQ-018 A word accepted on s_* SHALL appear on pin_in one cycle later if the FIFO was empty (latency 1).
REQ-019 pin_in_take with in_level > 0 SHALL pop the head; pin_in shows the next word the following cycle.
REQ-020 pin_in_take with in_level == 0 SHALL leave state unchanged and set err_underrun.
REQ-021 Simultaneous s_* transfer and pin_in_take on a non-empty input FIFO SHALL push and pop, in_level unchanged.
REQ-022 pin_out_strobe SHALL capture pin_out into the output FIFO when out_level < DEPTH.
REQ-023 pin_out_strobe with out_level == DEPTH and no same-cycle m_* transfer SHALL drop the word and set err_overflow.
REQ-024 pin_out_strobe with out_level == DEPTH and a same-cycle m_* transfer SHALL pop and push, no error, level unchanged.
REQ-025 m_valid SHALL be 1 exactly when out_level > 0; m_data SHALL be the output-FIFO head, held stable while m_valid && !m_ready.
REQ-026 Strobe-to-m_valid latency SHALL be 1 cycle from an empty output FIFO.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; words SHALL leave in arrival order.
REQ-028 err_clear SHALL clear both flags; if a same-cycle error event occurs, set SHALL win.
REQ-029 Pin strobes SHALL be treated as single-cycle level samples; an N-cycle-high strobe counts as N events.

Reset
REQ-030 rst_n low SHALL immediately force: both levels 0, pointers 0, s_ready 1, m_valid 0, pin_in 12'h000, m_data 12'h000, both error flags 0.
REQ-031 Reset mid-transfer SHALL discard all buffered words; no word SHALL emerge after rst_n rises unless newly pushed.
REQ-032 FIFO storage arrays need not be reset; only control state and outputs.

Structure
REQ-033 Package hvl_pkg SHALL hold WORD_W, the low/high pin split (8/4), and the default DEPTH.
REQ-034 One sub-module hvl_word_fifo (push, pop, full, empty, level, head) SHALL be instantiated twice: input and output paths.
REQ-035 Error-flag and pin-mapping logic SHALL live in hvl_io_bridge, not the FIFO.

Verification
REQ-036 Push 12'hABC, 12'h123; next cycle pin_in == 12'hABC; pulse pin_in_take -> pin_in == 12'h123, in_level 1.
REQ-037 Push 4 words with no take -> s_ready 0, in_level 4; fifth s_valid not accepted; one take -> s_ready 1.
REQ-038 pin_in_take on empty FIFO -> err_underrun 1, pin_in 12'h000; err_clear -> 0.
REQ-039 m_ready 0, strobe 5 words 12'h001..12'h005 -> out_level 4, err_overflow 1; drain yields 12'h001..12'h004 in order.
REQ-040 Full output FIFO, strobe 12'hFFF with m_ready 1 same cycle -> no overflow, last drained word 12'hFFF.
REQ-041 Assert rst_n low mid-stream with both FIFOs partly full -> all outputs at reset values immediately, m_valid stays 0 after release.
